// File: rtl/spike_rate_encoder.sv
// Stochastic rate encoder: turns one frame of per-channel intensities into
// WINDOW Bernoulli spike vectors, one per step_en strobe, for the reservoir's
// spike input (spikes_out + write).
module spike_rate_encoder #(
  parameter int          CHANNELS  = 16,
  parameter int          INT_WIDTH = 8,     // at most 16, one LFSR slice per channel
  parameter int          WINDOW    = 256,   // 1..65535
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*INT_WIDTH-1:0] in_data,
  input  logic                          step_en,
  input  logic                          abort,
  output logic [0:CHANNELS-1]           spikes_out,
  output logic                          spikes_valid,
  output logic                          write,
  output logic                          frame_done,
  output logic [15:0]                   total_spikes
);

  localparam int CNT_W = 17;
  localparam int POP_W = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_nxt;
  logic [CHANNELS*INT_WIDTH-1:0] frame_p0;
  logic [15:0]                   lfsr;
  logic [CNT_W-1:0]              step_cnt;
  logic [0:CHANNELS-1]           spk_nxt;
  logic [POP_W-1:0]              spk_pop;
  logic                          accept;
  logic                          last_step;

  // Fibonacci LFSR, taps 16,14,13,11; never leaves the nonzero cycle.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Per-channel random word: low bits of the LFSR rotated left by n.
  function automatic logic [INT_WIDTH-1:0] rnd_of(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = (s << n) | (s >> (16 - n));
    return r[INT_WIDTH-1:0];
  endfunction

  // Spike count accumulation clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [POP_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Bernoulli draw per channel; full-scale intensity is forced to always fire.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [INT_WIDTH-1:0] intens;
    logic [INT_WIDTH-1:0] rnd;
    assign intens     = frame_p0[(CHANNELS-1-g)*INT_WIDTH +: INT_WIDTH];
    assign rnd        = rnd_of(lfsr, g % 16);
    assign spk_nxt[g] = (&intens) | (rnd < intens);
  end

  // Number of spikes in the vector about to be emitted.
  always_comb begin
    spk_pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      spk_pop = spk_pop + POP_W'(spk_nxt[i]);
    end
  end

  assign accept    = in_valid & in_ready & ~reset;
  assign last_step = (state == RUN) & step_en & ~abort &
                     ((step_cnt + CNT_W'(1)) == CNT_W'(WINDOW));

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    write      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        write = 1'b1;
        if (abort)          state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame intensities are captured on acceptance and held for the whole frame.
  always_ff @(posedge clock) begin
    if (accept) frame_p0 <= in_data;
  end

  // Timestep engine: LFSR, step counter, spike vector and running total.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr         <= LFSR_SEED;
      step_cnt     <= '0;
      spikes_out   <= '0;
      spikes_valid <= 1'b0;
      total_spikes <= '0;
    end else begin
      spikes_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            lfsr         <= LFSR_SEED;
            step_cnt     <= '0;
            total_spikes <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            spikes_out <= '0;
          end else if (step_en) begin
            spikes_out   <= spk_nxt;
            spikes_valid <= 1'b1;
            lfsr         <= lfsr_step(lfsr);
            step_cnt     <= step_cnt + CNT_W'(1);
            total_spikes <= sat_add(total_spikes, spk_pop);
          end
        end
        DONE:    spikes_out <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: a WINDOW=256 instance for the main
// frame scenarios and a WINDOW=4 instance for the final-step/abort collision.
module tb_spike_rate_encoder;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // WINDOW=256 instance
  logic         rst = 1'b1, in_valid = 1'b0, step_en = 1'b0, abort = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, spikes_valid, write, frame_done;
  logic [0:15]  spikes_out;
  logic [15:0]  total_spikes;

  // WINDOW=4 instance
  logic         rst4 = 1'b1, in_valid4 = 1'b0, step_en4 = 1'b0, abort4 = 1'b0;
  logic [127:0] in_data4 = '0;
  logic         in_ready4, spikes_valid4, write4, frame_done4;
  logic [0:15]  spikes_out4;
  logic [15:0]  total_spikes4;

  spike_rate_encoder #(.CHANNELS(16), .INT_WIDTH(8), .WINDOW(256), .LFSR_SEED(16'hACE1)) dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .step_en(step_en), .abort(abort), .spikes_out(spikes_out), .spikes_valid(spikes_valid),
    .write(write), .frame_done(frame_done), .total_spikes(total_spikes));

  spike_rate_encoder #(.CHANNELS(16), .INT_WIDTH(8), .WINDOW(4), .LFSR_SEED(16'hACE1)) dut4 (
    .clock(clk), .reset(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .step_en(step_en4), .abort(abort4), .spikes_out(spikes_out4), .spikes_valid(spikes_valid4),
    .write(write4), .frame_done(frame_done4), .total_spikes(total_spikes4));

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] ALL_ZERO = '0;
  localparam logic [127:0] ALL_FF   = {128{1'b1}};
  localparam logic [127:0] MIXED    = {8'h00, 8'hFF, {14{8'h80}}};

  // Reference model of the spike generator
  logic [15:0] m_lfsr;

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [0:15] m_vec(input logic [15:0] s, input logic [127:0] d);
    logic [31:0] dd;
    logic [7:0]  iv, rv;
    logic [0:15] v;
    dd = {s, s};
    for (int i = 0; i < 16; i++) begin
      iv   = d[127-8*i -: 8];
      rv   = dd[16-i +: 8];
      v[i] = (iv == 8'hFF) || (rv < iv);
    end
    return v;
  endfunction

  // Results collected by run_frame
  int          r_pulses, r_model_err, r_valid_bad, r_write_bad, r_done_cnt, r_done_at;
  int          r_model_total, r_ffff_cnt;
  int          r_ones[16];
  logic        r_write_acc, r_ready_acc, r_ready_after, r_done_after;
  logic [0:15] r_spk_after;
  logic [15:0] r_total;
  logic [0:15] seq_cur[256];
  logic [0:15] seq_a[256];

  // Accept a frame on the 256-step instance and strobe every `period` cycles
  // until frame_done (bounded), gathering observations against the model.
  task automatic run_frame(input logic [127:0] d, input int period);
    logic [0:15] e;
    int cyc;
    in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    r_write_acc = write;
    r_ready_acc = in_ready;
    m_lfsr = 16'hACE1;
    r_pulses = 0; r_model_err = 0; r_valid_bad = 0; r_write_bad = 0;
    r_done_cnt = 0; r_done_at = -1; r_model_total = 0; r_ffff_cnt = 0;
    for (int i = 0; i < 16; i++) r_ones[i] = 0;
    cyc = 0;
    while (r_done_cnt == 0 && cyc < 1200) begin
      step_en = (cyc % period == 0);
      @(posedge clk); #1;
      if (step_en) begin
        e = m_vec(m_lfsr, d);
        m_lfsr = m_next(m_lfsr);
        if (!spikes_valid) r_valid_bad++;
        if (spikes_out !== e) r_model_err++;
        if (spikes_out === 16'hFFFF) r_ffff_cnt++;
        if (r_pulses < 256) seq_cur[r_pulses] = spikes_out;
        for (int i = 0; i < 16; i++) if (spikes_out[i]) r_ones[i]++;
        r_model_total += $countones(e);
        r_pulses++;
      end else if (spikes_valid) begin
        r_valid_bad++;
      end
      if (frame_done) begin
        r_done_cnt++;
        r_done_at = r_pulses;
      end else if (!write) begin
        r_write_bad++;
      end
      cyc++;
    end
    step_en = 1'b0;
    @(posedge clk); #1;
    r_ready_after = in_ready;
    r_done_after  = frame_done;
    r_spk_after   = spikes_out;
    r_total       = total_spikes;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1; in_valid = 1'b1; in_data = ALL_FF;
    @(posedge clk); #1;
    total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write_in_reset got=%b want=0", write); end
    in_valid = 1'b0; rst = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", write); end
    total++; if (spikes_out !== 16'h0000) begin bad++; $display("FAIL reset_spikes got=%h want=0000", spikes_out); end
    total++; if (total_spikes !== 16'h0000) begin bad++; $display("FAIL reset_total got=%0d want=0", total_spikes); end
    total++; if ({spikes_valid, frame_done} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {spikes_valid, frame_done}); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL reset_in_ready4 got=%b want=1", in_ready4); end
  endtask

  task automatic test_all_zero();
    run_frame(ALL_ZERO, 1);
    total++; if (r_write_acc !== 1'b1) begin bad++; $display("FAIL zero_write_latency got=%b want=1", r_write_acc); end
    total++; if (r_ready_acc !== 1'b0) begin bad++; $display("FAIL zero_ready_in_run got=%b want=0", r_ready_acc); end
    total++; if (r_pulses !== 256) begin bad++; $display("FAIL zero_pulses got=%0d want=256", r_pulses); end
    total++; if (r_ones[0] + r_ones[7] + r_ones[15] !== 0) begin bad++; $display("FAIL zero_spikes got=%0d want=0", r_ones[0] + r_ones[7] + r_ones[15]); end
    total++; if (r_model_err !== 0) begin bad++; $display("FAIL zero_vectors got=%0d bad vectors want=0", r_model_err); end
    total++; if (r_done_cnt !== 1 || r_done_at !== 256) begin bad++; $display("FAIL zero_done got cnt=%0d at=%0d want 1 at 256", r_done_cnt, r_done_at); end
    total++; if (r_done_after !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", r_done_after); end
    total++; if (r_total !== 16'd0) begin bad++; $display("FAIL zero_total got=%0d want=0", r_total); end
    total++; if (r_ready_after !== 1'b1) begin bad++; $display("FAIL zero_ready_after got=%b want=1", r_ready_after); end
  endtask

  task automatic test_all_ff();
    run_frame(ALL_FF, 3);
    total++; if (r_ffff_cnt !== 256) begin bad++; $display("FAIL ff_vectors got=%0d all-ones want=256", r_ffff_cnt); end
    total++; if (r_valid_bad !== 0) begin bad++; $display("FAIL ff_valid_strobe got=%0d bad cycles want=0", r_valid_bad); end
    total++; if (r_write_bad !== 0) begin bad++; $display("FAIL ff_write_run got=%0d low cycles want=0", r_write_bad); end
    total++; if (r_total !== 16'd4096) begin bad++; $display("FAIL ff_total got=%0d want=4096", r_total); end
    total++; if (r_spk_after !== 16'h0000) begin bad++; $display("FAIL ff_spikes_cleared got=%h want=0000", r_spk_after); end
  endtask

  task automatic test_mixed_repeat();
    int rate, diff;
    run_frame(MIXED, 1);
    seq_a = seq_cur;
    total++; if (r_ones[0] !== 0) begin bad++; $display("FAIL mix_ch0 got=%0d spikes want=0", r_ones[0]); end
    total++; if (r_ones[1] !== 256) begin bad++; $display("FAIL mix_ch1 got=%0d spikes want=256", r_ones[1]); end
    total++; if (r_model_err !== 0) begin bad++; $display("FAIL mix_model got=%0d bad vectors want=0", r_model_err); end
    total++; if (r_total !== 16'(r_model_total)) begin bad++; $display("FAIL mix_total got=%0d want=%0d", r_total, r_model_total); end
    rate = 0;
    for (int i = 2; i < 16; i++) rate += r_ones[i];
    total++; if (rate < 1577 || rate > 2007) begin bad++; $display("FAIL mix_rate got=%0d of 3584 want 1577..2007", rate); end
    run_frame(MIXED, 2);
    diff = 0;
    for (int i = 0; i < 256; i++) if (seq_cur[i] !== seq_a[i]) diff++;
    total++; if (diff !== 0) begin bad++; $display("FAIL mix_repeat got=%0d differing steps want=0", diff); end
  endtask

  task automatic test_abort();
    int exp_total, dn;
    in_data = MIXED; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_lfsr = 16'hACE1; exp_total = 0;
    for (int s = 0; s < 100; s++) begin
      step_en = 1'b1;
      @(posedge clk); #1;
      exp_total += $countones(m_vec(m_lfsr, MIXED));
      m_lfsr = m_next(m_lfsr);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; step_en = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b want=1", in_ready); end
    total++; if (write !== 1'b0) begin bad++; $display("FAIL abort_write got=%b want=0", write); end
    total++; if (spikes_out !== 16'h0000) begin bad++; $display("FAIL abort_spikes got=%h want=0000", spikes_out); end
    total++; if (spikes_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", spikes_valid); end
    total++; if (total_spikes !== 16'(exp_total)) begin bad++; $display("FAIL abort_total got=%0d want=%0d", total_spikes, exp_total); end
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      if (frame_done) dn++;
      @(posedge clk); #1;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_no_done got=%0d pulses want=0", dn); end
  endtask

  task automatic test_collision();
    int dn;
    // Normal 4-step frame first
    in_data4 = ALL_FF; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    dn = 0;
    for (int s = 0; s < 4; s++) begin
      step_en4 = 1'b1;
      @(posedge clk); #1;
    end
    step_en4 = 1'b0;
    total++; if ({spikes_valid4, frame_done4} !== 2'b11) begin bad++; $display("FAIL w4_done got=%b want=11", {spikes_valid4, frame_done4}); end
    total++; if (total_spikes4 !== 16'd64) begin bad++; $display("FAIL w4_total got=%0d want=64", total_spikes4); end
    @(posedge clk); #1;
    // Abort on the final strobe
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step_en4 = 1'b1;
      @(posedge clk); #1;
    end
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0; step_en4 = 1'b0;
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL coll_idle got=%b want=1", in_ready4); end
    total++; if (spikes_out4 !== 16'h0000) begin bad++; $display("FAIL coll_spikes got=%h want=0000", spikes_out4); end
    total++; if (total_spikes4 !== 16'd48) begin bad++; $display("FAIL coll_total got=%0d want=48", total_spikes4); end
    for (int c = 0; c < 3; c++) begin
      if (frame_done4) dn++;
      @(posedge clk); #1;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL coll_no_done got=%0d pulses want=0", dn); end
  endtask

  task automatic test_reset_mid();
    in_data = MIXED; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int s = 0; s < 50; s++) begin
      step_en = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; step_en = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%b want=1", in_ready); end
    total++; if (write !== 1'b0) begin bad++; $display("FAIL rmid_write got=%b want=0", write); end
    total++; if (spikes_out !== 16'h0000) begin bad++; $display("FAIL rmid_spikes got=%h want=0000", spikes_out); end
    total++; if (spikes_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", spikes_valid); end
    total++; if (total_spikes !== 16'd0) begin bad++; $display("FAIL rmid_total got=%0d want=0", total_spikes); end
    run_frame(MIXED, 1);
    total++; if (r_model_err !== 0) begin bad++; $display("FAIL rmid_reseed got=%0d bad vectors want=0", r_model_err); end
    total++; if (r_done_at !== 256) begin bad++; $display("FAIL rmid_len got=%0d want=256", r_done_at); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_ff();
    test_mixed_repeat();
    test_abort();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
Stochastic rate encoder that converts one frame of per-channel intensities into a Bernoulli spike train. It drives the LSM reservoir's spikes_in and write inputs, so it is the transmitting end of the reservoir's spike-input interface. A frame is accepted by valid/ready handshake, then emitted as WINDOW timesteps paced by step_en. Each timestep's spike probability per channel is proportional to that channel's intensity.

Parameters:
CHANNELS, 16, number of spike lines; matches reservoir Spike_neurons+1.
INT_WIDTH, 8, intensity bits per channel.
WINDOW, 256, timesteps per frame; range 1..65535.
LFSR_SEED, 16'hACE1, nonzero seed for the 16-bit LFSR.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  frame present on in_data.
in_ready  out  1  encoder can accept a frame.
in_data  in  CHANNELS*INT_WIDTH  intensities; channel 0 in the most significant INT_WIDTH bits.
step_en  in  1  timestep strobe; one spike vector per strobe.
abort  in  1  synchronous frame cancel.
spikes_out  out  [0:CHANNELS-1]  registered spike vector; bit 0 is channel 0.
spikes_valid  out  1  1-cycle pulse marking a new spikes_out vector.
write  out  1  reservoir write enable; high for the whole of RUN.
frame_done  out  1  1-cycle pulse after the last timestep.
total_spikes  out  16  saturating count of spikes emitted in the current or last frame.

Behaviour:
- Reset values: state=IDLE, spikes_out=0, spikes_valid=0, write=0, frame_done=0, total_spikes=0, step counter=0, LFSR=LFSR_SEED.
- Reset mid-frame returns to IDLE immediately at that edge; the partial frame is discarded.
- Handshakes are ignored in any cycle with reset=1.
- in_ready is combinational and equals (state==IDLE).
- States:
  - IDLE: on in_valid&in_ready, latch in_data, reseed LFSR=LFSR_SEED, clear total_spikes and step counter, go to RUN next cycle.
  - RUN: write=1. Each cycle with step_en=1 and abort=0:
    - spikes_out[i] <= (int[i]==all-ones) | (rnd[i] < int[i]).
    - spikes_valid <= 1.
    - LFSR advances one step.
    - Step counter increments.
    - total_spikes += popcount, saturating at 16'hFFFF.
  - Cycles with step_en=0 hold spikes_out, LFSR and counter, and keep spikes_valid=0.
  - When the counter reaches WINDOW on the final strobe, go to DONE.
  - DONE (one cycle): frame_done=1, write=0, spikes_out cleared to 0. Go to IDLE next cycle.
- Latency: frame accepted at edge N gives write=1 from cycle N+1. The first step_en sampled at edge M gives spikes_out/spikes_valid visible after edge M.
- LFSR:
  - Fibonacci form, taps 16,14,13,11.
  - rnd[i] = low INT_WIDTH bits of (LFSR rotated left by i).
  - The seed must be nonzero; the LFSR never reaches 0.
- Probability: int=0 never spikes; int=all-ones always spikes; otherwise P = int/2^INT_WIDTH.
- abort=1 in RUN: next state IDLE, spikes_out=0, write=0, no frame_done, total_spikes retained. abort in IDLE or DONE has no effect.
- in_valid during RUN/DONE is not accepted (in_ready=0). in_data must be held by the producer until accepted.
- Simultaneous abort and final step_en: abort wins, with no frame_done.
- Frames are deterministic: the same in_data always yields an identical spike sequence, because of the reseed at acceptance.

Test Plan:
- Reset check: hold reset 1 cycle, release. Required: in_ready=1, write=0, spikes_out=0, total_spikes=0. Drive in_valid with reset=1; no acceptance occurs.
- All-zero intensities, WINDOW=256, step_en every cycle. Required: 256 spikes_valid pulses with spikes_out=16'h0000; frame_done exactly 1 cycle after the 256th step; total_spikes=0; in_ready=1 after DONE.
- All 8'hFF intensities, step_en every 3rd cycle. Required: every vector is 16'hFFFF; spikes_valid only on strobe cycles; total_spikes=4096; write high throughout RUN.
- Mixed frame with ch0=8'h00, ch1=8'hFF, ch2..15=8'h80, run twice. Required: bit0 always 0, bit1 always 1; the two runs produce bit-identical sequences; ch2..15 spike rate within 0.5±0.06 over 256 steps.
- Abort at step 100 combined with a simultaneous final-step collision test (WINDOW=4, abort on the 4th strobe). Required: return to IDLE, no frame_done, spikes_out=0, total_spikes holds the pre-abort count.
- Reset asserted at step 50 mid-frame. Required: all outputs take reset values next edge; a subsequent frame starts at step 0 from LFSR_SEED.
